// File: rtl/fetch_controller_pkg.sv
// Shared fetch-stage definitions: state encoding, next-address selects and memory map constants.
// Decode and interrupt logic import the same constants.
package fetch_controller_pkg;

  localparam int PC_W    = 32;
  localparam int ADDR_W  = 20;
  localparam int EXT_BIT = 15;

  localparam logic [PC_W-1:0]   RESET_PC = 32'd32;
  localparam logic [ADDR_W-1:0] INT_VEC  = 20'd0;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    FETCH_HI = 2'd1,
    VEC_LO   = 2'd2,
    VEC_HI   = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_INC    = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_VEC    = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/fetch_controller_pc_next_mux.sv
// Next fetch-address select: hold, increment (mod 2**PC_W), branch redirect or interrupt vector.
module fetch_controller_pc_next_mux
  import fetch_controller_pkg::*;
(
  input  pc_sel_e          sel,
  input  logic [PC_W-1:0]  fa,
  input  logic [PC_W-1:0]  branch_target,
  input  logic [PC_W-1:0]  vector,
  output logic [PC_W-1:0]  fa_next
);

  // Select the fetch address for the next cycle
  always_comb begin
    fa_next = fa;
    case (sel)
      SEL_HOLD:   fa_next = fa;
      SEL_INC:    fa_next = fa + 32'd1;
      SEL_BRANCH: fa_next = branch_target;
      SEL_VEC:    fa_next = vector;
      default:    fa_next = fa;
    endcase
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: drives instruction-memory reads, assembles one/two-word instructions,
// and handles stalls, branch redirects and interrupt vectoring through the low memory words.
module fetch_controller
  import fetch_controller_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              int_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              int_ack,
  output logic [PC_W-1:0]   epc
);

  fetch_state_e    state_r, state_s;
  pc_sel_e         sel_s;
  logic [PC_W-1:0] fa_r, fa_next_s;
  logic [15:0]     first_r, first_s;
  logic [15:0]     lo_r, lo_s;
  logic [PC_W-1:0] pc_r, pc_s;
  logic [31:0]     instr_r, instr_s;
  logic            valid_r, valid_s;
  logic            int_ack_r, int_ack_s;
  logic [PC_W-1:0] epc_r, epc_s;
  logic [PC_W-1:0] vector_s;

  assign vector_s    = {imem_rdata, lo_r};
  assign pc          = pc_r;
  assign instr       = instr_r;
  assign instr_valid = valid_r;
  assign int_ack     = int_ack_r;
  assign epc         = epc_r;

  fetch_controller_pc_next_mux u_pc_next_mux (
    .sel           (sel_s),
    .fa            (fa_r),
    .branch_target (branch_target),
    .vector        (vector_s),
    .fa_next       (fa_next_s)
  );

  // Memory read address: vector words while vectoring, otherwise the fetch address
  always_comb begin
    imem_addr = fa_r[ADDR_W-1:0];
    case (state_r)
      VEC_LO:  imem_addr = INT_VEC;
      VEC_HI:  imem_addr = INT_VEC + 20'd1;
      default: imem_addr = fa_r[ADDR_W-1:0];
    endcase
  end

  // Next-state and output decode; branch beats stall beats interrupt beats sequencing
  always_comb begin
    state_s   = state_r;
    sel_s     = SEL_HOLD;
    first_s   = first_r;
    lo_s      = lo_r;
    pc_s      = pc_r;
    instr_s   = instr_r;
    valid_s   = 1'b0;
    int_ack_s = 1'b0;
    epc_s     = epc_r;
    if (branch_valid) begin
      state_s = FETCH;
      sel_s   = SEL_BRANCH;
    end else if (stall) begin
      valid_s = valid_r;
    end else begin
      case (state_r)
        FETCH: begin
          // int_ack high means the vector just landed; let its first instruction issue
          if (int_req && !int_ack_r) begin
            epc_s   = fa_r;
            state_s = VEC_LO;
          end else if (imem_rdata[EXT_BIT] == 1'b0) begin
            instr_s = {16'h0000, imem_rdata};
            pc_s    = fa_r;
            valid_s = 1'b1;
            sel_s   = SEL_INC;
          end else begin
            first_s = imem_rdata;
            sel_s   = SEL_INC;
            state_s = FETCH_HI;
          end
        end
        FETCH_HI: begin
          instr_s = {imem_rdata, first_r};
          pc_s    = fa_r - 32'd1;
          valid_s = 1'b1;
          sel_s   = SEL_INC;
          state_s = FETCH;
        end
        VEC_LO: begin
          lo_s    = imem_rdata;
          state_s = VEC_HI;
        end
        VEC_HI: begin
          sel_s     = SEL_VEC;
          int_ack_s = 1'b1;
          state_s   = FETCH;
        end
        default: begin
          state_s = FETCH;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= FETCH;
      fa_r      <= RESET_PC;
      first_r   <= 16'h0000;
      lo_r      <= 16'h0000;
      pc_r      <= 32'h0000_0000;
      instr_r   <= 32'h0000_0000;
      valid_r   <= 1'b0;
      int_ack_r <= 1'b0;
      epc_r     <= 32'h0000_0000;
    end else begin
      state_r   <= state_s;
      fa_r      <= fa_next_s;
      first_r   <= first_s;
      lo_r      <= lo_s;
      pc_r      <= pc_s;
      instr_r   <= instr_s;
      valid_r   <= valid_s;
      int_ack_r <= int_ack_s;
      epc_r     <= epc_s;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: sequencing, two-word fetch, interrupts, branch, stall, reset, wrap.
module tb_fetch_controller;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        int_req;
  logic [19:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        int_ack;
  logic [31:0] epc;

  logic [15:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  assign imem_rdata = mem[imem_addr[9:0]];

  fetch_controller dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .int_req       (int_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .int_ack       (int_ack),
    .epc           (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i) & 16'h7fff;
    mem[0] = 16'h0100;
    mem[1] = 16'h0000;
    reset = 1'b1; stall = 1'b0; branch_valid = 1'b0; branch_target = 32'h0; int_req = 1'b0;
    #12;
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_instr", 64'(instr), 64'h0);
    chk("rst_valid", 64'(instr_valid), 64'h0);
    chk("rst_ack", 64'(int_ack), 64'h0);
    chk("rst_epc", 64'(epc), 64'h0);
    chk("rst_addr", 64'(imem_addr), 64'd32);

    // sequential one-word fetch
    tick(); reset = 1'b0;
    tick();
    chk("seq_valid0", 64'(instr_valid), 64'h1);
    chk("seq_pc0", 64'(pc), 64'd32);
    chk("seq_instr0", 64'(instr), 64'h0000_0020);
    tick(); chk("seq_pc1", 64'(pc), 64'd33);
    tick(); chk("seq_pc2", 64'(pc), 64'd34);
    for (int i = 0; i < 5; i++) tick();
    chk("seq_pc39", 64'(pc), 64'd39);

    // interrupt at fa=40
    int_req = 1'b1;
    tick();
    chk("int_valid", 64'(instr_valid), 64'h0);
    chk("int_epc", 64'(epc), 64'd40);
    chk("int_addr_lo", 64'(imem_addr), 64'd0);
    tick();
    chk("int_ack_early", 64'(int_ack), 64'h0);
    chk("int_addr_hi", 64'(imem_addr), 64'd1);
    tick();
    chk("int_ack", 64'(int_ack), 64'h1);
    chk("int_ack_valid", 64'(instr_valid), 64'h0);
    tick();
    chk("vec_pc", 64'(pc), 64'd256);
    chk("vec_valid", 64'(instr_valid), 64'h1);
    chk("vec_ack_drop", 64'(int_ack), 64'h0);
    int_req = 1'b0;

    // two-word instruction after a fresh reset
    mem[32] = 16'h8001;
    mem[33] = 16'hABCD;
    reset = 1'b1; #2; reset = 1'b0;
    tick();
    chk("tw_first_valid", 64'(instr_valid), 64'h0);
    tick();
    chk("tw_valid", 64'(instr_valid), 64'h1);
    chk("tw_instr", 64'(instr), 64'hABCD_8001);
    chk("tw_pc", 64'(pc), 64'd32);
    tick();
    chk("tw_next_pc", 64'(pc), 64'd34);

    // interrupt raised while in FETCH_HI
    mem[35] = 16'h8007;
    mem[36] = 16'h1111;
    tick();
    int_req = 1'b1;
    chk("ih_first_valid", 64'(instr_valid), 64'h0);
    tick();
    chk("ih_instr", 64'(instr), 64'h1111_8007);
    chk("ih_pc", 64'(pc), 64'd35);
    tick();
    chk("ih_epc", 64'(epc), 64'd37);
    chk("ih_valid", 64'(instr_valid), 64'h0);
    tick(); tick();
    chk("ih_ack", 64'(int_ack), 64'h1);
    int_req = 1'b0;
    tick();
    chk("ih_vec_pc", 64'(pc), 64'd256);

    // branch wins over stall, then stall holds
    stall = 1'b1; branch_valid = 1'b1; branch_target = 32'h0000_0200;
    tick();
    chk("br_valid", 64'(instr_valid), 64'h0);
    branch_valid = 1'b0;
    tick();
    chk("br_stall_valid", 64'(instr_valid), 64'h0);
    chk("br_stall_pc", 64'(pc), 64'd256);
    stall = 1'b0;
    tick();
    chk("br_pc", 64'(pc), 64'd512);
    chk("br_instr", 64'(instr), 64'h0000_0200);
    stall = 1'b1;
    tick();
    chk("stall_hold_valid", 64'(instr_valid), 64'h1);
    chk("stall_hold_pc", 64'(pc), 64'd512);
    stall = 1'b0;

    // branch during VEC_HI abandons the interrupt
    int_req = 1'b1;
    tick();
    chk("ab_epc", 64'(epc), 64'd513);
    int_req = 1'b0;
    tick();
    branch_valid = 1'b1; branch_target = 32'h0000_0300;
    tick();
    chk("ab_ack", 64'(int_ack), 64'h0);
    chk("ab_valid", 64'(instr_valid), 64'h0);
    branch_valid = 1'b0;
    tick();
    chk("ab_pc", 64'(pc), 64'd768);
    chk("ab_ack2", 64'(int_ack), 64'h0);
    chk("ab_epc_kept", 64'(epc), 64'd513);

    // async reset in the middle of a two-word fetch
    mem[769] = 16'h8009;
    tick();
    chk("mid_fh_valid", 64'(instr_valid), 64'h0);
    #2; reset = 1'b1; #1;
    chk("mid_rst_pc", 64'(pc), 64'h0);
    chk("mid_rst_instr", 64'(instr), 64'h0);
    chk("mid_rst_epc", 64'(epc), 64'h0);
    mem[32] = 16'h0020;
    tick(); reset = 1'b0;
    tick();
    chk("restart_pc", 64'(pc), 64'd32);
    chk("restart_valid", 64'(instr_valid), 64'h1);

    // PC wrap from all-ones to zero
    branch_valid = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    branch_valid = 1'b0;
    chk("wrap_addr", 64'(imem_addr), 64'hF_FFFF);
    tick();
    chk("wrap_pc_max", 64'(pc), 64'hFFFF_FFFF);
    chk("wrap_instr_max", 64'(instr), 64'h0000_03FF);
    tick();
    chk("wrap_pc_zero", 64'(pc), 64'h0);
    chk("wrap_instr_zero", 64'(instr), 64'h0000_0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
